sega_z80_decrypt_unit: RTL and testbench
========================================

Name: sega_z80_decrypt_unit

Overview:
Table-driven opcode/data decrypter for Sega-style encrypted Z80 program ROMs. It sits between the program ROM data bus and the main CPU data input. It is the parametrised successor of the fixed-table decrypter. Differences from the fixed version:
- Translation table is a writable 128x8 RAM.
- The RAM is auto-initialised at reset from a built-in default table.
- The table is reloadable at run time through the download port.
- The encrypted window and the address tap positions are parameters.
- A registered, bypassable output path.

Parameters:
ADDR_W, 16, CPU address width.
WIN_LO, 16'h0000, first address (inclusive) of the encrypted window.
WIN_HI, 16'h7FFF, last address (inclusive) of the encrypted window.
TAP3, 12, address bit used as table index bit 6.
TAP2, 8, address bit used as table index bit 5.
TAP1, 4, address bit used as table index bit 4.
TAP0, 0, address bit used as table index bit 3.

Ports:
i_CLK  in  1  system clock
i_RST  in  1  synchronous reset, active high
i_CEN  in  1  lookup clock enable (CPU read-sample cadence)
i_ADDR  in  ADDR_W  CPU address
i_MREQ_n  in  1  CPU memory request
i_M1_n  in  1  CPU opcode-fetch strobe
i_DI  in  8  raw ROM data
o_DO  out  8  decrypted (or passed-through) data to CPU
o_HIT  out  1  o_DO was decrypted on this output
i_DECR_EN  in  1  0 = global bypass
i_TBL_WE  in  1  table write strobe
i_TBL_ADDR  in  7  table write/readback index
i_TBL_DATA  in  8  table write data
o_TBL_Q  out  8  table readback data
o_BUSY  out  1  default-table initialisation in progress

Behaviour:
Reset values:
- i_RST=1 forces o_DO=8'h00, o_HIT=0, o_TBL_Q=8'h00, o_BUSY=1.
- FSM goes to INIT and the init counter clears to 0.
- Reset asserted mid-INIT or mid-RUN restarts INIT from entry 0.

FSM state INIT:
- Writes default entry k to RAM[k] at k=0..127, one entry per clock. i_CEN is ignored.
- After entry 127 is written, the FSM moves to RUN and o_BUSY falls on that same edge. o_BUSY is high for exactly 128 clocks after reset release.
- i_TBL_WE is ignored in INIT.
- o_DO carries registered raw i_DI with o_HIT=0.

Default table, addressed by index {tap3,tap2,tap1,tap0,M1_n,d5^d7,d3^d7}:
- Opcode rows (M1_n=0) for upper nibble values 0,1,2,5,8,11,14: 20,00,A0,80.
- Opcode rows for 3,4,6,9,10,12,15: 88,08,80,00.
- Opcode rows for 7,13: 28,A8,08,88.
- Data rows (M1_n=1) for 0,1,2,5,8,11,14: A8,A0,88,80.
- Data rows for 3,4,6,9,10,12,15: A0,80,A8,88.
- Data rows for 7,13: 88,80,08,00.

FSM state RUN, lookup:
- On each edge with i_CEN=1: idx = {i_ADDR[TAP3],i_ADDR[TAP2],i_ADDR[TAP1],i_ADDR[TAP0],i_M1_n,i_DI[5]^i_DI[7],i_DI[3]^i_DI[7]}.
- hit = i_DECR_EN & ~i_MREQ_n & (WIN_LO <= i_ADDR <= WIN_HI).
- If hit: o_DO <= {e[7]^d7, d6, e[5]^d7, d4, e[3]^d7, d2, d1, d0}, where e=RAM[idx] and d=i_DI.
- If not hit: o_DO <= i_DI.
- o_HIT <= hit.
- Latency is exactly 1 clock from the sampled inputs. Entry bits other than 7, 5 and 3 are ignored.
- With i_CEN=0, o_DO and o_HIT hold.

Table write:
- i_TBL_WE=1 in RUN writes i_TBL_DATA to RAM[i_TBL_ADDR] on that edge, independent of i_CEN.
- If a lookup and a write hit the same index on the same edge, the lookup uses the old entry (read-before-write). The new entry is visible from the next lookup.

Readback:
- o_TBL_Q <= RAM[i_TBL_ADDR] every clock, in any state.
- Readback is also read-before-write.

Window bounds:
- A range is valid if it lies inside 0..2^ADDR_W-1.
- WIN_LO > WIN_HI means an empty window: the block always passes through.

Test Plan:
- Reset release: o_BUSY stays high 128 clocks and then falls; o_DO=00 while reset is held; readback RAM[0]=20, RAM[7]=80, RAM[0x38]=28, RAM[0x7F]=88.
- RUN, MREQ_n=0, M1_n=0, ADDR=0000, DI=00: idx 0, e=20 -> o_DO=20, o_HIT=1, one clock after the sample.
- Same as above with M1_n=1: idx 4, e=A8 -> o_DO=A8. With ADDR=8000 (outside window): o_DO=00, o_HIT=0.
- DI=FF, M1_n=0, ADDR=0000: idx 0, e=20 -> o_DO=DF. With i_DECR_EN=0 -> o_DO=FF, o_HIT=0.
- Write RAM[0]=00 on the same edge as an idx-0 lookup with DI=00: that lookup returns 20, the next lookup returns 00, and readback shows 00.
- Assert i_RST for 1 clock at INIT count 60: o_BUSY stays high a further 128 clocks; a user-written entry reverts to its default. i_CEN=0 holds o_DO steady across DI changes.

Source files
------------

// File: rtl/sega_z80_decrypt_unit.sv
// Table-driven opcode/data decrypter for Sega-style encrypted Z80 program ROMs.
// A 128x8 translation RAM is filled from a built-in default table after reset.
module sega_z80_decrypt_unit #(
  parameter int unsigned       ADDR_W = 16,
  parameter logic [ADDR_W-1:0] WIN_LO = 16'h0000,
  parameter logic [ADDR_W-1:0] WIN_HI = 16'h7FFF,
  parameter int unsigned       TAP3   = 12,
  parameter int unsigned       TAP2   = 8,
  parameter int unsigned       TAP1   = 4,
  parameter int unsigned       TAP0   = 0
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic              i_CEN,
  input  logic [ADDR_W-1:0] i_ADDR,
  input  logic              i_MREQ_n,
  input  logic              i_M1_n,
  input  logic [7:0]        i_DI,
  output logic [7:0]        o_DO,
  output logic              o_HIT,
  input  logic              i_DECR_EN,
  input  logic              i_TBL_WE,
  input  logic [6:0]        i_TBL_ADDR,
  input  logic [7:0]        i_TBL_DATA,
  output logic [7:0]        o_TBL_Q,
  output logic              o_BUSY
);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  // Default entry for index {tap3,tap2,tap1,tap0,m1_n,d5^d7,d3^d7}.
  function automatic logic [7:0] default_entry(input logic [6:0] idx);
    logic [1:0]  grp;
    logic [31:0] row;
    logic [7:0]  e;
    case (idx[6:3])
      4'd3, 4'd4, 4'd6, 4'd9, 4'd10, 4'd12, 4'd15: grp = 2'd1;
      4'd7, 4'd13:                                 grp = 2'd2;
      default:                                     grp = 2'd0;
    endcase
    case ({grp, idx[2]})
      3'b000:  row = 32'h2000_A080;
      3'b010:  row = 32'h8808_8000;
      3'b100:  row = 32'h28A8_0888;
      3'b001:  row = 32'hA8A0_8880;
      3'b011:  row = 32'hA080_A888;
      3'b101:  row = 32'h8880_0800;
      default: row = 32'h0000_0000;
    endcase
    case (idx[1:0])
      2'd0:    e = row[31:24];
      2'd1:    e = row[23:16];
      2'd2:    e = row[15:8];
      default: e = row[7:0];
    endcase
    return e;
  endfunction

  state_e     state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic [7:0] do_q, do_d;
  logic       hit_q, hit_d;
  logic [7:0] rdbk_q, rdbk_d;
  logic [7:0] mem_q [128];

  logic       mem_we;
  logic [6:0] mem_waddr;
  logic [7:0] mem_wdata;

  logic [6:0] lut_idx;
  logic [7:0] lut_e;
  logic [7:0] dec_data;
  logic       above_lo, below_hi, hit;

  // Compare only against bounds that actually restrict the address range.
  if (WIN_LO == '0) begin : g_lo_open
    assign above_lo = 1'b1;
  end else begin : g_lo_cmp
    assign above_lo = (i_ADDR >= WIN_LO);
  end

  if (WIN_HI == {ADDR_W{1'b1}}) begin : g_hi_open
    assign below_hi = 1'b1;
  end else begin : g_hi_cmp
    assign below_hi = (i_ADDR <= WIN_HI);
  end

  assign hit = i_DECR_EN & ~i_MREQ_n & above_lo & below_hi;

  assign lut_idx = {i_ADDR[TAP3], i_ADDR[TAP2], i_ADDR[TAP1], i_ADDR[TAP0],
                    i_M1_n, i_DI[5] ^ i_DI[7], i_DI[3] ^ i_DI[7]};
  assign lut_e   = mem_q[lut_idx];

  // Bits 7/5/3 become entry bit xor d7; all other bits pass straight through.
  assign dec_data = (i_DI & 8'h57) | ((lut_e ^ {8{i_DI[7]}}) & 8'hA8);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    do_d      = do_q;
    hit_d     = hit_q;
    rdbk_d    = mem_q[i_TBL_ADDR];
    mem_we    = 1'b0;
    mem_waddr = i_TBL_ADDR;
    mem_wdata = i_TBL_DATA;
    unique case (state_q)
      StInit: begin
        mem_we    = ~i_RST;
        mem_waddr = cnt_q;
        mem_wdata = default_entry(cnt_q);
        cnt_d     = cnt_q + 7'd1;
        do_d      = i_DI;
        hit_d     = 1'b0;
        if (cnt_q == 7'd127) begin
          state_d = StRun;
        end
      end
      StRun: begin
        mem_we = i_TBL_WE & ~i_RST;
        if (i_CEN) begin
          do_d  = hit ? dec_data : i_DI;
          hit_d = hit;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q <= StInit;
      cnt_q   <= '0;
      do_q    <= '0;
      hit_q   <= 1'b0;
      rdbk_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      do_q    <= do_d;
      hit_q   <= hit_d;
      rdbk_q  <= rdbk_d;
    end
  end

  // Table RAM: reads above are combinational, so same-edge lookups see the old entry.
  always_ff @(posedge i_CLK) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign o_DO    = do_q;
  assign o_HIT   = hit_q;
  assign o_TBL_Q = rdbk_q;
  assign o_BUSY  = (state_q == StInit);

endmodule

// File: tb/tb_sega_z80_decrypt_unit.sv
// Directed bench for sega_z80_decrypt_unit: expected lookups are queued at
// drive time and popped when the registered output appears.
module tb_sega_z80_decrypt_unit;

  logic        i_CLK;
  logic        i_RST;
  logic        i_CEN;
  logic [15:0] i_ADDR;
  logic        i_MREQ_n;
  logic        i_M1_n;
  logic [7:0]  i_DI;
  logic [7:0]  o_DO;
  logic        o_HIT;
  logic        i_DECR_EN;
  logic        i_TBL_WE;
  logic [6:0]  i_TBL_ADDR;
  logic [7:0]  i_TBL_DATA;
  logic [7:0]  o_TBL_Q;
  logic        o_BUSY;

  typedef struct {
    string      tag;
    logic [7:0] d;
    logic       h;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   busy_cnt;

  sega_z80_decrypt_unit dut (
    .i_CLK      (i_CLK),
    .i_RST      (i_RST),
    .i_CEN      (i_CEN),
    .i_ADDR     (i_ADDR),
    .i_MREQ_n   (i_MREQ_n),
    .i_M1_n     (i_M1_n),
    .i_DI       (i_DI),
    .o_DO       (o_DO),
    .o_HIT      (o_HIT),
    .i_DECR_EN  (i_DECR_EN),
    .i_TBL_WE   (i_TBL_WE),
    .i_TBL_ADDR (i_TBL_ADDR),
    .i_TBL_DATA (i_TBL_DATA),
    .o_TBL_Q    (o_TBL_Q),
    .o_BUSY     (o_BUSY)
  );

  initial i_CLK = 1'b0;
  always #5 i_CLK = ~i_CLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Drive one sampled CPU read and compare its result one clock later.
  task automatic lookup(input string tag, input logic [15:0] a, input logic m1n,
                        input logic [7:0] di, input logic [7:0] exp_do, input logic exp_hit);
    exp_t e;
    @(negedge i_CLK);
    i_ADDR = a;
    i_M1_n = m1n;
    i_DI   = di;
    i_CEN  = 1'b1;
    exp_q.push_back('{tag: tag, d: exp_do, h: exp_hit});
    @(posedge i_CLK);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 8'h00, 8'h01);
    end else begin
      e = exp_q.pop_front();
      check({e.tag, "_do"}, o_DO, e.d);
      check({e.tag, "_hit"}, {7'b0, o_HIT}, {7'b0, e.h});
    end
  endtask

  task automatic readback(input string tag, input logic [6:0] a, input logic [7:0] exp);
    @(negedge i_CLK);
    i_TBL_ADDR = a;
    @(posedge i_CLK);
    #1;
    check(tag, o_TBL_Q, exp);
  endtask

  // Count clocks until o_BUSY falls, bounded so a stuck DUT still ends.
  task automatic count_busy(output int n);
    n = 0;
    while (n < 300) begin
      @(posedge i_CLK);
      #1;
      n++;
      if (n == 1) begin
        check("init_do_raw", o_DO, i_DI);
        check("init_hit", {7'b0, o_HIT}, 8'h00);
      end
      if (!o_BUSY) break;
    end
  endtask

  initial begin
    i_RST      = 1'b1;
    i_CEN      = 1'b0;
    i_ADDR     = 16'h0000;
    i_MREQ_n   = 1'b0;
    i_M1_n     = 1'b0;
    i_DI       = 8'h5A;
    i_DECR_EN  = 1'b1;
    i_TBL_WE   = 1'b0;
    i_TBL_ADDR = 7'h00;
    i_TBL_DATA = 8'h00;

    repeat (3) @(posedge i_CLK);
    #1;
    check("rst_do", o_DO, 8'h00);
    check("rst_hit", {7'b0, o_HIT}, 8'h00);
    check("rst_tblq", o_TBL_Q, 8'h00);
    check("rst_busy", {7'b0, o_BUSY}, 8'h01);

    // Release reset with a table write held high; INIT must ignore it.
    @(negedge i_CLK);
    i_RST      = 1'b0;
    i_TBL_WE   = 1'b1;
    i_TBL_ADDR = 7'h7F;
    i_TBL_DATA = 8'h55;
    count_busy(busy_cnt);
    i_TBL_WE = 1'b0;
    check("busy_len", busy_cnt[7:0], 8'd128);

    readback("rb_00", 7'h00, 8'h20);
    readback("rb_07", 7'h07, 8'h80);
    readback("rb_38", 7'h38, 8'h28);
    readback("rb_7f", 7'h7F, 8'h88);
    readback("rb_44", 7'h44, 8'hA8);
    readback("rb_1a", 7'h1A, 8'h80);

    lookup("op_idx0",   16'h0000, 1'b0, 8'h00, 8'h20, 1'b1);
    lookup("data_idx4", 16'h0000, 1'b1, 8'h00, 8'hA8, 1'b1);
    lookup("out_win",   16'h8000, 1'b1, 8'h00, 8'h00, 1'b0);
    lookup("win_hi",    16'h7FFF, 1'b0, 8'h00, 8'h88, 1'b1);
    lookup("op_ff",     16'h0000, 1'b0, 8'hFF, 8'hDF, 1'b1);
    lookup("tap_c",     16'h0111, 1'b1, 8'hA0, 8'h28, 1'b1);
    i_DECR_EN = 1'b0;
    lookup("bypass",    16'h0000, 1'b0, 8'hFF, 8'hFF, 1'b0);
    i_DECR_EN = 1'b1;
    i_MREQ_n  = 1'b1;
    lookup("no_mreq",   16'h0000, 1'b0, 8'h3C, 8'h3C, 1'b0);
    i_MREQ_n  = 1'b0;

    // Write entry 0 on the same edge as an idx-0 lookup and readback.
    i_TBL_ADDR = 7'h00;
    i_TBL_DATA = 8'h00;
    i_TBL_WE   = 1'b1;
    lookup("rbw_old",   16'h0000, 1'b0, 8'h00, 8'h20, 1'b1);
    check("rbw_tblq_old", o_TBL_Q, 8'h20);
    i_TBL_WE = 1'b0;
    lookup("rbw_new",   16'h0000, 1'b0, 8'hFF, 8'hFF, 1'b1);
    check("rbw_tblq_new", o_TBL_Q, 8'h00);

    // Clock enable low: output holds while DI moves.
    @(negedge i_CLK);
    i_CEN = 1'b0;
    i_DI  = 8'h12;
    @(posedge i_CLK);
    #1;
    check("cen_hold1", o_DO, 8'hFF);
    @(negedge i_CLK);
    i_DI = 8'h34;
    @(posedge i_CLK);
    #1;
    check("cen_hold2", o_DO, 8'hFF);
    check("cen_hold_hit", {7'b0, o_HIT}, 8'h01);

    // Reset, then reset again at INIT count 60.
    @(negedge i_CLK);
    i_RST = 1'b1;
    @(negedge i_CLK);
    i_RST = 1'b0;
    repeat (60) @(posedge i_CLK);
    @(negedge i_CLK);
    i_RST = 1'b1;
    @(posedge i_CLK);
    #1;
    check("rst2_busy", {7'b0, o_BUSY}, 8'h01);
    check("rst2_do", o_DO, 8'h00);
    @(negedge i_CLK);
    i_RST = 1'b0;
    count_busy(busy_cnt);
    check("busy_len2", busy_cnt[7:0], 8'd128);
    readback("rb_00_revert", 7'h00, 8'h20);
    lookup("op_after_rst", 16'h0000, 1'b0, 8'h00, 8'h20, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
